// File: rtl/xsleena_map_rom_fetch_if.sv
// ----------------------------------------------------------------------------
// xsleena_map_rom_fetch_if
// Bundles the MAP-stage ROM request/response signals and the SDRAM ROM
// channel handshake that pass through the MAP ROM fetch bridge.
//   ROM_req / req_ROM_addr : one-cycle request pulse + word address (MAP side)
//   ROM_data / rom_valid   : registered returned word + freshness flag
//   sdram_req / sdram_addr : level request + word address to the controller
//   sdram_ack / sdram_data : one-cycle ack with read data (controller side)
// Modports:
//   master : the surroundings of the bridge (MAP stage and SDRAM controller)
//   slave  : the fetch bridge itself
// ----------------------------------------------------------------------------
interface xsleena_map_rom_fetch_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int SDRAM_AW   = 24
);
   logic                  ROM_req;
   logic [ADDR_WIDTH-1:0] req_ROM_addr;
   logic [15:0]           ROM_data;
   logic                  rom_valid;
   logic                  sdram_req;
   logic [SDRAM_AW-1:0]   sdram_addr;
   logic                  sdram_ack;
   logic [15:0]           sdram_data;

   modport master (
      output ROM_req, req_ROM_addr, sdram_ack, sdram_data,
      input  ROM_data, rom_valid, sdram_req, sdram_addr
   );

   modport slave (
      input  ROM_req, req_ROM_addr, sdram_ack, sdram_data,
      output ROM_data, rom_valid, sdram_req, sdram_addr
   );
endinterface

// File: rtl/xsleena_map_rom_fetch.sv
// ----------------------------------------------------------------------------
// xsleena_map_rom_fetch
// Bridges the MAP tilemap stage's ROM requests onto the shared SDRAM ROM
// channel. Repeated requests for the word already held are served locally,
// only the newest outstanding request is kept (latest wins), and a fixed
// SDRAM base offset is added to every address.
// Ports:
//   clk        : master clock, rising edge
//   reset      : synchronous, active-high
//   bus        : slave side of xsleena_map_rom_fetch_if (MAP request/response
//                and SDRAM request/ack/data)
//   fill_count : saturating count of fills delivered to ROM_data
// ----------------------------------------------------------------------------
module xsleena_map_rom_fetch #(
   parameter int                  ADDR_WIDTH = 15,
   parameter int                  SDRAM_AW   = 24,
   parameter logic [SDRAM_AW-1:0] ROM_BASE   = 24'h000000
) (
   input  logic                     clk,
   input  logic                     reset,
   xsleena_map_rom_fetch_if.slave   bus,
   output logic [15:0]              fill_count
);

   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] infl_addr;   // address currently on the SDRAM bus
   logic [ADDR_WIDTH-1:0] pend_addr;   // single pending slot, latest wins
   logic                  pend;
   logic [ADDR_WIDTH-1:0] tag;         // address whose word sits in ROM_data
   logic                  tag_vld;

   logic                  hit;
   logic [ADDR_WIDTH-1:0] reissue_addr;

   // Truncating add: wrap at 2^SDRAM_AW is intentional.
   function automatic logic [SDRAM_AW-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
      return ROM_BASE + SDRAM_AW'(a);
   endfunction

   assign hit = tag_vld && (bus.req_ROM_addr == tag);

   // A request arriving in the DROP cycle itself is newer than the slot.
   assign reissue_addr = bus.ROM_req ? bus.req_ROM_addr : pend_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         infl_addr      <= '0;
         pend_addr      <= '0;
         pend           <= 1'b0;
         tag            <= '0;
         tag_vld        <= 1'b0;
         bus.ROM_data   <= 16'h0000;
         bus.rom_valid  <= 1'b0;
         bus.sdram_req  <= 1'b0;
         bus.sdram_addr <= '0;
         fill_count     <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               // Acks seen here are spurious and dropped.
               if (bus.ROM_req && !hit) begin
                  bus.sdram_req  <= 1'b1;
                  bus.sdram_addr <= map_addr(bus.req_ROM_addr);
                  infl_addr      <= bus.req_ROM_addr;
                  bus.rom_valid  <= 1'b0;
                  state          <= BUSY;
               end
            end

            BUSY: begin
               if (bus.sdram_ack) begin
                  bus.sdram_req <= 1'b0;
                  if (!pend) begin
                     bus.ROM_data <= bus.sdram_data;
                     tag          <= infl_addr;
                     tag_vld      <= 1'b1;
                     if (fill_count != 16'hFFFF)
                        fill_count <= fill_count + 16'd1;
                     // A request in the ack cycle is ordered after the ack,
                     // so it is compared against the word just written.
                     if (bus.ROM_req && (bus.req_ROM_addr != infl_addr)) begin
                        pend          <= 1'b1;
                        pend_addr     <= bus.req_ROM_addr;
                        bus.rom_valid <= 1'b0;
                        state         <= DROP;
                     end else begin
                        bus.rom_valid <= 1'b1;
                        state         <= IDLE;
                     end
                  end else begin
                     // Stale data: discard and re-issue after one low cycle.
                     // The acked word is dropped, so even a request for the
                     // same address must be fetched again.
                     if (bus.ROM_req)
                        pend_addr <= bus.req_ROM_addr;
                     state <= DROP;
                  end
               end else if (bus.ROM_req) begin
                  // Re-requesting the in-flight word cancels any pending one.
                  pend_addr <= bus.req_ROM_addr;
                  pend      <= (bus.req_ROM_addr != infl_addr);
               end
            end

            DROP: begin
               // sdram_req was low for this one cycle; re-issue now.
               bus.sdram_req  <= 1'b1;
               bus.sdram_addr <= map_addr(reissue_addr);
               infl_addr      <= reissue_addr;
               pend           <= 1'b0;
               state          <= BUSY;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xsleena_map_rom_fetch.sv
// ----------------------------------------------------------------------------
// tb_xsleena_map_rom_fetch
// Drives two bridges (base 0 and base 24'h100000) with identical stimulus.
// A transaction-level model tracks the latest requested address, whether a
// fetch is outstanding, the held tag and the expected ROM_data/fill_count.
// ----------------------------------------------------------------------------
module tb_xsleena_map_rom_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] fc0, fc1;

   always #5 clk = ~clk;

   xsleena_map_rom_fetch_if #(.ADDR_WIDTH(15), .SDRAM_AW(24)) bus0 ();
   xsleena_map_rom_fetch_if #(.ADDR_WIDTH(15), .SDRAM_AW(24)) bus1 ();

   xsleena_map_rom_fetch #(.ADDR_WIDTH(15), .SDRAM_AW(24), .ROM_BASE(24'h000000)) u0 (
      .clk(clk), .reset(reset), .bus(bus0), .fill_count(fc0));
   xsleena_map_rom_fetch #(.ADDR_WIDTH(15), .SDRAM_AW(24), .ROM_BASE(24'h100000)) u1 (
      .clk(clk), .reset(reset), .bus(bus1), .fill_count(fc1));

   int errors = 0;
   int checks = 0;

   // model state
   logic [15:0] exp_data, exp_cnt;
   bit          exp_valid, active, tag_v, lat_v, prev_req;
   logic [14:0] tag, lat, infl;
   logic [23:0] prev_addr;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_data = 16'h0; exp_cnt = 16'h0; exp_valid = 0; active = 0;
      tag_v = 0; lat_v = 0; prev_req = 0; prev_addr = '0;
      tag = '0; lat = '0; infl = '0;
   endtask

   task automatic model_check();
      chk("rom_data", {16'h0, bus0.ROM_data}, {16'h0, exp_data});
      chk("fill_count", {16'h0, fc0}, {16'h0, exp_cnt});
      chk("rom_valid", {31'h0, bus0.rom_valid}, {31'h0, exp_valid});
      if (!active) chk("idle_req_low", {31'h0, bus0.sdram_req}, 32'h0);
      if (bus0.sdram_req && !prev_req) begin
         chk("issue_is_latest", {8'h0, bus0.sdram_addr}, {17'h0, lat});
         infl = lat;
      end
      if (bus0.sdram_req && prev_req)
         chk("addr_held", {8'h0, bus0.sdram_addr}, {8'h0, prev_addr});
      if (bus1.sdram_req)
         chk("base_offset", {8'h0, bus1.sdram_addr}, {8'h0, 24'(bus0.sdram_addr + 24'h100000)});
      prev_req  = bus0.sdram_req;
      prev_addr = bus0.sdram_addr;
   endtask

   task automatic drive(input bit r, input logic [14:0] a, input bit k, input logic [15:0] d);
      bus0.ROM_req = r; bus0.req_ROM_addr = a; bus0.sdram_ack = k; bus0.sdram_data = d;
      bus1.ROM_req = r; bus1.req_ROM_addr = a; bus1.sdram_ack = k; bus1.sdram_data = d;
   endtask

   // One clock with the given inputs; the model is advanced from the rules
   // (ack first, then any request in the same cycle), then checked.
   task automatic step(input bit r, input logic [14:0] a, input bit k, input logic [15:0] d);
      bit obs_req;
      obs_req = bus0.sdram_req;
      drive(r, a, k, d);
      if (k && obs_req && lat_v && (lat == infl)) begin
         exp_data  = d;
         exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
         tag       = infl;
         tag_v     = 1;
         exp_valid = 1;
         active    = 0;
      end
      if (r) begin
         if (active) exp_valid = 0;
         else if (!(tag_v && a == tag)) begin
            active    = 1;
            exp_valid = 0;
         end
         lat   = a;
         lat_v = 1;
      end
      @(posedge clk); #1;
      drive(0, '0, 0, '0);
      model_check();
   endtask

   task automatic do_reset();
      drive(0, '0, 0, '0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      chk("rst_rom_data", {16'h0, bus0.ROM_data}, 32'h0);
      chk("rst_rom_valid", {31'h0, bus0.rom_valid}, 32'h0);
      chk("rst_sdram_req", {31'h0, bus0.sdram_req}, 32'h0);
      chk("rst_sdram_addr", {8'h0, bus0.sdram_addr}, 32'h0);
      chk("rst_fill_count", {16'h0, fc0}, 32'h0);
   endtask

   initial begin
      logic [14:0] a;
      bit          r, k;
      drive(0, '0, 0, '0);
      model_clear();
      do_reset();

      // basic miss and fill
      step(1, 15'h0010, 0, 16'h0);
      chk("miss_req", {31'h0, bus0.sdram_req}, 32'h1);
      chk("miss_addr", {8'h0, bus0.sdram_addr}, 32'h000010);
      step(0, '0, 1, 16'hA55A);
      chk("fill_data", {16'h0, bus0.ROM_data}, 32'hA55A);
      chk("fill_valid", {31'h0, bus0.rom_valid}, 32'h1);
      chk("fill_cnt", {16'h0, fc0}, 32'h1);

      // repeat address hits
      step(1, 15'h0010, 0, 16'h0);
      chk("hit_no_req", {31'h0, bus0.sdram_req}, 32'h0);
      step(0, '0, 0, 16'h0);
      chk("hit_data", {16'h0, bus0.ROM_data}, 32'hA55A);
      chk("hit_cnt", {16'h0, fc0}, 32'h1);

      // latest wins
      step(1, 15'h0020, 0, 16'h0);
      step(1, 15'h0021, 0, 16'h0);
      step(1, 15'h0022, 0, 16'h0);
      chk("lw_addr_held", {8'h0, bus0.sdram_addr}, 32'h000020);
      step(0, '0, 1, 16'h1111);
      chk("lw_drop_low", {31'h0, bus0.sdram_req}, 32'h0);
      chk("lw_discard", {16'h0, bus0.ROM_data}, 32'hA55A);
      step(0, '0, 0, 16'h0);
      chk("lw_reissue_req", {31'h0, bus0.sdram_req}, 32'h1);
      chk("lw_reissue_addr", {8'h0, bus0.sdram_addr}, 32'h000022);
      step(0, '0, 1, 16'h2222);
      chk("lw_data", {16'h0, bus0.ROM_data}, 32'h2222);
      chk("lw_cnt", {16'h0, fc0}, 32'h2);

      // base offset at top of address range
      step(1, 15'h7FFF, 0, 16'h0);
      chk("base_top", {8'h0, bus1.sdram_addr}, 32'h107FFF);
      step(0, '0, 1, 16'h7777);

      // request in the ack cycle: deliver, one DROP cycle, then issue
      step(1, 15'h0020, 0, 16'h0);
      step(1, 15'h0030, 1, 16'h2020);
      chk("sim_data", {16'h0, bus0.ROM_data}, 32'h2020);
      chk("sim_drop", {31'h0, bus0.sdram_req}, 32'h0);
      chk("sim_cnt", {16'h0, fc0}, 32'h4);
      step(0, '0, 0, 16'h0);
      chk("sim_issue", {8'h0, bus0.sdram_addr}, 32'h000030);
      step(0, '0, 1, 16'h3030);

      // request in the ack cycle hitting the just-written tag
      step(1, 15'h0031, 0, 16'h0);
      step(1, 15'h0031, 1, 16'h3131);
      step(0, '0, 0, 16'h0);
      chk("simhit_idle", {31'h0, bus0.sdram_req}, 32'h0);
      chk("simhit_valid", {31'h0, bus0.rom_valid}, 32'h1);

      // re-request of the in-flight address cancels the pending one
      step(1, 15'h0050, 0, 16'h0);
      step(1, 15'h0051, 0, 16'h0);
      step(1, 15'h0050, 0, 16'h0);
      step(0, '0, 1, 16'h5050);
      chk("cancel_data", {16'h0, bus0.ROM_data}, 32'h5050);
      chk("cancel_cnt", {16'h0, fc0}, 32'h7);

      // spurious ack while idle
      step(0, '0, 1, 16'hBEEF);
      chk("spur_data", {16'h0, bus0.ROM_data}, 32'h5050);

      // reset while busy, late ack, then tag must be invalid
      step(1, 15'h0060, 0, 16'h0);
      do_reset();
      step(0, '0, 0, 16'h0);
      step(0, '0, 1, 16'hDEAD);
      chk("late_ack_req", {31'h0, bus0.sdram_req}, 32'h0);
      chk("late_ack_data", {16'h0, bus0.ROM_data}, 32'h0);
      chk("late_ack_cnt", {16'h0, fc0}, 32'h0);
      step(1, 15'h0050, 0, 16'h0);
      chk("post_rst_miss", {31'h0, bus0.sdram_req}, 32'h1);
      chk("post_rst_addr", {8'h0, bus0.sdram_addr}, 32'h000050);
      step(0, '0, 1, 16'h0A0A);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 2) == 0);
         a = ($urandom_range(0, 15) == 0) ? 15'($urandom) : 15'($urandom_range(0, 7));
         k = bus0.sdram_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         step(r, a, k, 16'($urandom));
      end
      for (int i = 0; i < 200 && active; i++)
         step(0, '0, bus0.sdram_req, 16'($urandom));
      chk("drain_timeout", {31'h0, active}, 32'h0);
      step(0, '0, 0, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xsleena_map_rom_fetch.md
Name: xsleena_map_rom_fetch

Overview:
- Bridges the MAP tilemap stage's ROM request interface (one-cycle request pulse plus word address) to the shared SDRAM ROM channel.
- Sits directly between the MAP stage and the SDRAM controller port.
- Returns the 16-bit ROM word on a registered data bus that the MAP stage samples. That bus holds its value until the next fill completes.
- Filters repeated addresses, keeps only the newest outstanding request (latest wins), and adds a fixed SDRAM base offset.

Parameters:
- ADDR_WIDTH, 15, width of the word address from the MAP stage.
- SDRAM_AW, 24, width of the SDRAM word address.
- ROM_BASE, 24'h000000, SDRAM word offset of the reordered MAP ROM region.

Ports:
- clk  in  1  master clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ROM_req  in  1  one-cycle request pulse from the MAP stage.
- req_ROM_addr  in  ADDR_WIDTH  requested word address; valid when ROM_req=1.
- ROM_data  out  16  last fetched word; held between fills.
- rom_valid  out  1  high once ROM_data corresponds to the most recent accepted request.
- sdram_req  out  1  level request to the SDRAM controller; held until sdram_ack.
- sdram_addr  out  SDRAM_AW  ROM_BASE + zero-extended address; stable while sdram_req=1.
- sdram_ack  in  1  one-cycle pulse; sdram_data is valid in the same cycle.
- sdram_data  in  16  SDRAM read data.
- fill_count  out  16  saturating count of completed fills that were delivered to ROM_data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - ROM_data=16'h0000, rom_valid=0, sdram_req=0, sdram_addr=0, fill_count=0.
  - State IDLE, pending flag clear, held address tag invalid.
- State machine:
  - IDLE:
    - ROM_req with address equal to the valid held tag is a hit: no SDRAM access, rom_valid stays 1.
    - ROM_req with any other address is a miss: next cycle sdram_req=1, sdram_addr=ROM_BASE+addr, rom_valid=0, state BUSY.
  - BUSY:
    - sdram_req and sdram_addr are held constant until sdram_ack.
    - A new ROM_req in BUSY overwrites the single pending slot (latest wins) and sets the pending flag. This holds even if the new address equals the in-flight address; in that case pending is cleared instead (no duplicate fetch).
    - On sdram_ack with pending clear: ROM_data<=sdram_data, tag<=in-flight address, rom_valid<=1, fill_count increments (saturates at 16'hFFFF). State returns to IDLE, and sdram_req deasserts in the same registered update.
    - On sdram_ack with pending set: the acked data is discarded (ROM_data unchanged, rom_valid stays 0, fill_count unchanged). sdram_req drops for exactly one cycle (DROP), then re-asserts with the pending address. Pending clears and state stays in BUSY via DROP.
  - DROP: a one-cycle state that guarantees a controller-visible sdram_req low between transactions. A ROM_req arriving in DROP updates the pending address used on re-issue.
- Simultaneous events:
  - ROM_req in the same cycle as sdram_ack is treated as arriving after the ack.
  - If that request hits the just-written tag, it is a hit.
  - Otherwise it starts the next miss: IDLE is skipped, a DROP cycle is taken, then the request is issued.
- Latency: a miss from IDLE gives sdram_req high on cycle t+1 after ROM_req. ROM_data updates on the cycle after sdram_ack, and rom_valid rises with it.
- Spurious input: sdram_ack while IDLE or DROP is ignored.
- Reset mid-transaction:
  - sdram_req drops next cycle and state goes to IDLE.
  - A late sdram_ack after reset is ignored.
  - The tag is invalidated, so the first request after reset is always a miss.
- Width and wrap: sdram_addr = ROM_BASE + {zeros, req_ROM_addr}, truncated to SDRAM_AW; wrap at 2^SDRAM_AW is allowed and not flagged.

Test Plan:
- Reset, then ROM_req addr=15'h0010 -> next cycle sdram_req=1, sdram_addr=24'h000010. Ack with data=16'hA55A -> ROM_data=16'hA55A, rom_valid=1, fill_count=1 one cycle after ack.
- Repeat ROM_req addr=15'h0010 after that fill -> sdram_req stays 0, ROM_data unchanged, fill_count=1.
- Latest wins:
  - Stimulus: request 15'h0020, then 15'h0021 and 15'h0022 while BUSY; ack the first with 16'h1111, then ack the next with 16'h2222.
  - Response: 16'h1111 discarded; one low cycle on sdram_req; re-issue at 0x0022; final ROM_data=16'h2222, fill_count increments by 1 only.
- ROM_BASE=24'h100000, request 15'h7FFF -> sdram_addr=24'h107FFF.
- Simultaneous: ROM_req 15'h0030 in the ack cycle of 15'h0020 -> 0x0020 data delivered, one DROP cycle, then sdram_req re-asserts with addr 0x0030.
- Assert reset while BUSY, then pulse sdram_ack two cycles later -> sdram_req=0, ROM_data=0, rom_valid=0, fill_count=0. The ack is ignored, and the next request to the old address issues a new fetch.
